// File: rtl/coin_manager_pkg.sv
// Shared types and constants for the coin manager and its BCD score counter.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [9:0] COIN_W_DEF   = 10'd16;
    localparam logic [9:0] COIN_H_DEF   = 10'd28;
    localparam logic [9:0] PLAYER_W_DEF = 10'd16;
    localparam logic [9:0] PLAYER_H_DEF = 10'd32;
    localparam logic [7:0] BCD_MAX      = 8'h99;

    // Next value of a 2-digit BCD count; holds once it reaches 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        if (value == BCD_MAX) begin
            return value;
        end else if (value[3:0] == 4'd9) begin
            return {value[7:4] + 4'd1, 4'd0};
        end else begin
            return {value[7:4], value[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/coin_manager_bcd_counter2.sv
// Two-digit BCD counter for the coin total; saturates at 99.
module bcd_counter2
    import coin_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= 8'h00;
        end else if (inc) begin
            count <= bcd_inc(count);
        end
    end

endmodule

// File: rtl/coin_manager.sv
// Tracks which level coins are still live and, once per frame, retires any
// live coin touching the player, one coin per Clk cycle.
module coin_manager
    import coin_pkg::*;
#(
    parameter int         NUM_COINS = 4,
    parameter logic [9:0] COIN_W    = COIN_W_DEF,
    parameter logic [9:0] COIN_H    = COIN_H_DEF,
    parameter logic [9:0] PLAYER_W  = PLAYER_W_DEF,
    parameter logic [9:0] PLAYER_H  = PLAYER_H_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic                    game_active,
    input  logic [9:0]              player_x,
    input  logic [9:0]              player_y,
    input  logic [NUM_COINS*10-1:0] coin_x,
    input  logic [NUM_COINS*10-1:0] coin_y,
    output logic [NUM_COINS-1:0]    coin_alive,
    output logic                    eat_pulse,
    output logic [3:0]              eat_idx,
    output logic [7:0]              coin_count,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_COINS - 1);

    state_t               state;
    logic [3:0]           idx;
    logic                 frame_clk_delayed;
    logic                 frame_edge;
    logic [9:0]           cx;
    logic [9:0]           cy;
    logic                 hit;
    logic [NUM_COINS-1:0] eat_vec;
    logic                 eat;

    always_comb begin
        cx = '0;
        cy = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (idx == 4'(i)) begin
                cx = coin_x[10*i +: 10];
                cy = coin_y[10*i +: 10];
            end
        end
    end

    // Widened to 11 bits so coins near the right/bottom world edge do not wrap.
    assign hit = ({1'b0, player_x} < ({1'b0, cx} + {1'b0, COIN_W}))
              && ({1'b0, cx} < ({1'b0, player_x} + {1'b0, PLAYER_W}))
              && ({1'b0, player_y} < ({1'b0, cy} + {1'b0, COIN_H}))
              && ({1'b0, cy} < ({1'b0, player_y} + {1'b0, PLAYER_H}));

    always_comb begin
        eat_vec = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            eat_vec[i] = coin_alive[i] & (idx == 4'(i)) & hit & (state == SCAN);
        end
    end

    assign eat = |eat_vec;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state             <= IDLE;
            idx               <= 4'd0;
            busy              <= 1'b0;
            overrun           <= 1'b0;
            frame_clk_delayed <= 1'b0;
            frame_edge        <= 1'b0;
            coin_alive        <= '1;
            eat_pulse         <= 1'b0;
            eat_idx           <= 4'd0;
        end else begin
            frame_clk_delayed <= frame_clk;
            frame_edge        <= frame_clk & ~frame_clk_delayed;
            eat_pulse         <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_edge && game_active) begin
                        state <= SCAN;
                        idx   <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (frame_edge) begin
                        overrun <= 1'b1;
                    end
                    if (eat) begin
                        coin_alive <= coin_alive & ~eat_vec;
                        eat_pulse  <= 1'b1;
                        eat_idx    <= idx;
                    end
                    // busy drops as we enter DONE so it reads low during the gap cycle.
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                DONE: begin
                    if (frame_edge) begin
                        overrun <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    bcd_counter2 u_bcd_counter2 (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (eat),
        .count (coin_count)
    );

endmodule

// File: tb/tb_coin_manager.sv
// Scoreboard bench for coin_manager: stimulus queues expected eat events,
// a negedge monitor checks every eat pulse against the queue.
module tb_coin_manager;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        game_active;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic [39:0] coin_x;
    logic [39:0] coin_y;
    logic [3:0]  coin_alive;
    logic        eat_pulse;
    logic [3:0]  eat_idx;
    logic [7:0]  coin_count;
    logic        busy;
    logic        overrun;

    logic        bcd_rst;
    logic        bcd_inc_in;
    logic [7:0]  bcd_cnt;

    coin_manager dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .game_active (game_active),
        .player_x    (player_x),
        .player_y    (player_y),
        .coin_x      (coin_x),
        .coin_y      (coin_y),
        .coin_alive  (coin_alive),
        .eat_pulse   (eat_pulse),
        .eat_idx     (eat_idx),
        .coin_count  (coin_count),
        .busy        (busy),
        .overrun     (overrun)
    );

    bcd_counter2 u_bcd (
        .Clk   (Clk),
        .Reset (bcd_rst),
        .inc   (bcd_inc_in),
        .count (bcd_cnt)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         at_cyc;
        logic [3:0] idx;
        logic [7:0] cnt;
        logic [3:0] alive;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every eat pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (eat_pulse === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_eat: idx %0d count %h at cyc %0d, none expected",
                         eat_idx, coin_count, cyc);
            end else begin
                e = sb.pop_front();
                if (cyc != e.at_cyc || eat_idx !== e.idx || coin_count !== e.cnt
                    || coin_alive !== e.alive) begin
                    n_bad++;
                    $display("FAIL eat_event: got cyc %0d idx %0d count %h alive %b, expected cyc %0d idx %0d count %h alive %b",
                             cyc, eat_idx, coin_count, coin_alive,
                             e.at_cyc, e.idx, e.cnt, e.alive);
                end
            end
        end
    end

    task automatic push(input int at, input logic [3:0] i, input logic [7:0] c, input logic [3:0] a);
        exp_t e;
        e.at_cyc = at;
        e.idx    = i;
        e.cnt    = c;
        e.alive  = a;
        sb.push_back(e);
    endtask

    task automatic set_coin(input int i, input logic [9:0] x, input logic [9:0] y);
        coin_x[10*i +: 10] = x;
        coin_y[10*i +: 10] = y;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Raises frame_clk just after a posedge; n is the cycle number of that posedge.
    // The registered edge is then high in the following cycle (T), coin i shows at n+3+i.
    task automatic frame_up(output int n);
        @(posedge Clk);
        #1;
        frame_clk = 1'b1;
        n = cyc;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] alive, input logic [7:0] cnt,
                                 input logic bsy, input logic ovr);
        check({tag, "_alive"}, 16'(coin_alive), 16'(alive));
        check({tag, "_count"}, 16'(coin_count), 16'(cnt));
        check({tag, "_busy"}, 16'(busy), 16'(bsy));
        check({tag, "_overrun"}, 16'(overrun), 16'(ovr));
    endtask

    task automatic bcd_pulses(input int n);
        @(negedge Clk);
        bcd_inc_in = 1'b1;
        repeat (n) @(negedge Clk);
        bcd_inc_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish by time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        Reset       = 1'b1;
        bcd_rst     = 1'b1;
        bcd_inc_in  = 1'b0;
        frame_clk   = 1'b0;
        game_active = 1'b1;
        player_x    = 10'd100;
        player_y    = 10'd300;
        coin_x      = '0;
        coin_y      = '0;
        set_coin(0, 10'd500, 10'd100);
        set_coin(1, 10'd700, 10'd50);
        set_coin(2, 10'd300, 10'd400);
        set_coin(3, 10'd800, 10'd200);
        tick(2);
        Reset   = 1'b0;
        bcd_rst = 1'b0;
        tick(5);
        @(negedge Clk);
        check_outputs("reset", 4'b1111, 8'h00, 1'b0, 1'b0);
        check("reset_eat_pulse", 16'(eat_pulse), 16'd0);
        check("reset_eat_idx", 16'(eat_idx), 16'd0);

        // Single overlap on coin 1.
        set_coin(1, 10'd110, 10'd300);
        frame_up(n);
        push(n + 4, 4'd1, 8'h01, 4'b1101);
        wait_cyc(n + 2);
        check("scan1_busy_start", 16'(busy), 16'd1);
        wait_cyc(n + 5);
        check("scan1_busy_last", 16'(busy), 16'd1);
        wait_cyc(n + 6);
        check("scan1_busy_done", 16'(busy), 16'd0);
        frame_clk = 1'b0;
        wait_cyc(n + 10);

        // Still overlapping a dead coin: nothing happens.
        frame_up(n);
        wait_cyc(n + 3);
        frame_clk = 1'b0;
        wait_cyc(n + 10);
        check_outputs("dead_coin", 4'b1101, 8'h01, 1'b0, 1'b0);

        // Coins 0 and 3 overlap; game_active dropped mid-scan does not abort.
        do_reset();
        set_coin(0, 10'd100, 10'd300);
        set_coin(1, 10'd500, 10'd100);
        set_coin(2, 10'd700, 10'd50);
        set_coin(3, 10'd90, 10'd290);
        frame_up(n);
        push(n + 3, 4'd0, 8'h01, 4'b1110);
        push(n + 6, 4'd3, 8'h02, 4'b0110);
        wait_cyc(n + 4);
        game_active = 1'b0;
        frame_clk   = 1'b0;
        wait_cyc(n + 10);
        game_active = 1'b1;
        check_outputs("two_coins", 4'b0110, 8'h02, 1'b0, 1'b0);

        // Touching edges never count; one pixel of overlap does.
        do_reset();
        set_coin(0, 10'd84, 10'd300);
        set_coin(1, 10'd116, 10'd300);
        set_coin(2, 10'd100, 10'd272);
        set_coin(3, 10'd100, 10'd332);
        frame_up(n);
        wait_cyc(n + 3);
        frame_clk = 1'b0;
        wait_cyc(n + 10);
        check_outputs("touching", 4'b1111, 8'h00, 1'b0, 1'b0);
        set_coin(3, 10'd100, 10'd331);
        frame_up(n);
        push(n + 6, 4'd3, 8'h01, 4'b0111);
        wait_cyc(n + 3);
        frame_clk = 1'b0;
        wait_cyc(n + 10);

        // Near the right world edge: the hitbox sum must not wrap.
        player_x = 10'd1015;
        set_coin(2, 10'd1010, 10'd300);
        frame_up(n);
        push(n + 5, 4'd2, 8'h02, 4'b0011);
        wait_cyc(n + 3);
        frame_clk = 1'b0;
        wait_cyc(n + 10);

        // game_active low in IDLE: edge ignored, no overrun.
        set_coin(0, 10'd1015, 10'd300);
        game_active = 1'b0;
        frame_up(n);
        wait_cyc(n + 3);
        check("inactive_busy", 16'(busy), 16'd0);
        frame_clk = 1'b0;
        wait_cyc(n + 10);
        check_outputs("inactive", 4'b0011, 8'h02, 1'b0, 1'b0);
        game_active = 1'b1;

        // Second edge two cycles into the scan: flagged and ignored.
        frame_up(n);
        push(n + 3, 4'd0, 8'h03, 4'b0010);
        @(posedge Clk);
        #1;
        frame_clk = 1'b0;
        @(posedge Clk);
        #1;
        frame_clk = 1'b1;
        wait_cyc(n + 3);
        check("overrun_before", 16'(overrun), 16'd0);
        wait_cyc(n + 5);
        check("overrun_set", 16'(overrun), 16'd1);
        frame_clk = 1'b0;
        wait_cyc(n + 6);
        check("overrun_busy_done", 16'(busy), 16'd0);
        wait_cyc(n + 8);
        check("overrun_no_rescan", 16'(busy), 16'd0);
        wait_cyc(n + 12);
        check_outputs("overrun_end", 4'b0010, 8'h03, 1'b0, 1'b1);

        // Reset in the middle of a scan that would have eaten coin 1.
        set_coin(1, 10'd1000, 10'd310);
        frame_up(n);
        wait_cyc(n + 2);
        frame_clk = 1'b0;
        wait_cyc(n + 3);
        check("midscan_busy", 16'(busy), 16'd1);
        Reset = 1'b1;
        wait_cyc(n + 4);
        check_outputs("midscan_reset", 4'b1111, 8'h00, 1'b0, 1'b0);
        check("midscan_eat_pulse", 16'(eat_pulse), 16'd0);
        Reset = 1'b0;
        wait_cyc(n + 12);
        check_outputs("after_reset", 4'b1111, 8'h00, 1'b0, 1'b0);

        // BCD carry and saturation on a standalone counter.
        bcd_pulses(9);
        check("bcd_09", 16'(bcd_cnt), 16'h09);
        bcd_pulses(1);
        check("bcd_10", 16'(bcd_cnt), 16'h10);
        bcd_pulses(9);
        check("bcd_19", 16'(bcd_cnt), 16'h19);
        bcd_pulses(1);
        check("bcd_20", 16'(bcd_cnt), 16'h20);
        bcd_pulses(79);
        check("bcd_99", 16'(bcd_cnt), 16'h99);
        bcd_pulses(3);
        check("bcd_sat", 16'(bcd_cnt), 16'h99);

        tick(3);
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_manager.md
Name: coin_manager

Overview:
- Owns the alive state of all level coins and drives each coin sprite's coin_alive input.
- Once per frame, scans every live coin against the player bounding box, one coin per Clk cycle, in world coordinates.
- On overlap, the coin is retired, a one-cycle eat pulse is raised, and a 2-digit BCD coin counter is incremented for the score display.
- Sits between the player motion block, the coin sprite instances and the HUD/score block.

Parameters:
- NUM_COINS, 4, number of managed coins (1..16)
- COIN_W, 10'd16, coin hitbox width in pixels
- COIN_H, 10'd28, coin hitbox height in pixels
- PLAYER_W, 10'd16, player hitbox width in pixels
- PLAYER_H, 10'd32, player hitbox height in pixels

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- frame_clk  input  1  VGA vsync-derived frame tick, asynchronous to Clk phase
- game_active  input  1  scans occur only while high
- player_x  input  10  player left edge, world coordinates
- player_y  input  10  player top edge
- coin_x  input  NUM_COINS*10  packed coin left edges; coin i at bits [10i+9:10i]
- coin_y  input  NUM_COINS*10  packed coin top edges
- coin_alive  output  NUM_COINS  bit i high while coin i is live
- eat_pulse  output  1  one Clk cycle high per coin retired
- eat_idx  output  4  index of the coin retired; valid with eat_pulse
- coin_count  output  8  BCD count, [7:4] tens, [3:0] ones
- busy  output  1  high while the scan is in progress
- overrun  output  1  sticky; a frame edge arrived while busy

Behaviour:
- Reset values: coin_alive all ones, eat_pulse 0, eat_idx 0, coin_count 8'h00, busy 0, overrun 0, state IDLE, idx 0. The frame_clk edge-detect registers also clear.
- Edge detect:
  - frame_clk_delayed <= frame_clk.
  - edge <= frame_clk & ~frame_clk_delayed.
  - edge is high for exactly one Clk cycle per frame.
- State machine (IDLE, SCAN, DONE):
  - IDLE: if edge and game_active, go to SCAN with idx=0 and busy=1. Otherwise stay in IDLE.
  - SCAN: evaluate coin idx in this cycle. If idx==NUM_COINS-1, go to DONE; else idx++.
  - DONE: busy=0, go to IDLE. This is one cycle, so there is one idle gap before the next scan.
- Timing: edge high in cycle T.
  - SCAN occupies cycles T+1 .. T+NUM_COINS.
  - Coin i is evaluated in cycle T+1+i. Its coin_alive, eat_pulse, eat_idx and coin_count updates are visible at T+2+i.
- Overlap test, all strict, computed in 11-bit unsigned so sums cannot wrap:
  - player_x < cx+COIN_W
  - cx < player_x+PLAYER_W
  - player_y < cy+COIN_H
  - cy < player_y+PLAYER_H
- Eat action: taken when coin_alive[idx] is set and the coin overlaps the player.
  - Clear coin_alive[idx].
  - eat_pulse=1 for one cycle, eat_idx=idx.
  - BCD increment of coin_count.
- A dead coin never re-arms. Only Reset restores it.
- BCD counter:
  - ones 9 -> 0 with a carry into tens.
  - Saturates at 8'h99: the pulse still fires, the count holds.
- Multiple coins overlapping in one frame each retire in their own scan cycle, giving separate pulses and separate increments.
- Player position and coin positions are sampled live in each SCAN cycle. They are not latched at the frame edge.
- Frame edge while state is SCAN or DONE: the edge is ignored and overrun is set (sticky until Reset).
- game_active low:
  - In IDLE, edges are ignored and overrun is not set.
  - Dropping game_active mid-scan does not abort the scan.
- Reset mid-scan: everything returns to its reset value on the next Clk edge, including coins already retired.

Decomposition:
- Package coin_pkg:
  - state enum {IDLE, SCAN, DONE}
  - constants COIN_W_DEF, COIN_H_DEF, BCD_MAX=8'h99
- Sub-module bcd_counter2: synchronous 2-digit BCD counter with inc, saturating at 99. Instantiated once.

Test Plan:
- Reset, then no frame edges -> coin_alive=4'b1111, coin_count=8'h00, busy=0, eat_pulse never high.
- Player (100,300), coin1 at (110,300), others far away, one frame edge at T -> at T+3 coin_alive=4'b1101, eat_pulse=1 with eat_idx=1, coin_count=8'h01; busy low from T+5.
- Player stays overlapping coin1 for a second frame -> no eat_pulse, count stays 8'h01.
- Coins 0 and 3 both overlapping -> pulses at T+2 (idx 0) and T+5 (idx 3), coin_count=8'h02, coin_alive=4'b0110.
- Touching edges only, player_x=cx+16 -> no eat. Preload count 8'h09 then eat -> 8'h10. Preload 8'h99 then eat -> stays 8'h99 with a pulse.
- Two frame edges 2 cycles apart -> overrun=1 and only one scan runs. Assert Reset mid-scan -> all outputs return to reset values next cycle.
